// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared pipeline types and scoreboard sizing constants.
package reg_scoreboard_pkg;
  localparam int NREG = 32;
  localparam int CNT_W = 2;
  typedef logic [4:0] creg_addr_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback side of the register-hazard scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;
  logic issue_valid;
  logic issue_wen;
  creg_addr_t issue_wa;
  creg_addr_t ra1;
  creg_addr_t ra2;
  logic wb_valid;
  creg_addr_t wb_wa;
  logic flush;
  logic busy1;
  logic busy2;
  logic issue_stall;
  logic issue_fire;
  logic sb_empty;
  logic sb_err;
  modport master (
    output issue_valid, issue_wen, issue_wa, ra1, ra2, wb_valid, wb_wa, flush,
    input busy1, busy2, issue_stall, issue_fire, sb_empty, sb_err
  );
  modport slave (
    input issue_valid, issue_wen, issue_wa, ra1, ra2, wb_valid, wb_wa, flush,
    output busy1, busy2, issue_stall, issue_fire, sb_empty, sb_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// sb_entry: pending-write counter for one architectural register.
module sb_entry #(
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output logic             uf
);
  // a writeback with nothing pending is an underflow unless paired with an issue
  assign uf = dec && !inc && cnt == '0;
  always_ff @(posedge clk)
    if (reset || flush) cnt <= '0;
    else if (inc && !dec) cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks pending register writes and stalls decode on hazards.
module reg_scoreboard #(
  parameter int NREG = reg_scoreboard_pkg::NREG,
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W,
  parameter bit WB_BYPASS = 1'b1,
  parameter bit WAW_STALL = 1'b1
) (
  input logic clk,
  input logic reset,
  reg_scoreboard_if.slave sb
);
  import reg_scoreboard_pkg::*;
  localparam int TOT_W = $clog2(NREG * (2 ** CNT_W - 1) + 1);
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0] uf;
  logic [TOT_W-1:0] tot;
  logic wbc, waw, sat, inc_any, dec_eff, err_q;
  assign cnt[0] = '0;
  assign uf[0] = 1'b0;
  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry #(.CNT_W(CNT_W)) u_ent (
      .clk(clk),
      .reset(reset),
      .inc(inc_any && sb.issue_wa == creg_addr_t'(r)),
      .dec(sb.wb_valid && sb.wb_wa == creg_addr_t'(r)),
      .flush(sb.flush),
      .cnt(cnt[r]),
      .uf(uf[r])
    );
  end
  // wbc: this cycle's writeback retires the last pending write of wb_wa
  assign wbc = WB_BYPASS && sb.wb_valid && sb.wb_wa != '0 && cnt[sb.wb_wa] == CNT_W'(1);
  assign sb.busy1 = sb.ra1 != '0 && cnt[sb.ra1] != '0 && !(wbc && sb.wb_wa == sb.ra1);
  assign sb.busy2 = sb.ra2 != '0 && cnt[sb.ra2] != '0 && !(wbc && sb.wb_wa == sb.ra2);
  assign waw = WAW_STALL && sb.issue_wen && sb.issue_wa != '0 && cnt[sb.issue_wa] != '0
               && !(wbc && sb.wb_wa == sb.issue_wa);
  assign sat = sb.issue_wen && sb.issue_wa != '0 && &cnt[sb.issue_wa];
  assign sb.issue_stall = sb.issue_valid && (sb.busy1 || sb.busy2 || waw || sat);
  assign sb.issue_fire = sb.issue_valid && !sb.issue_stall && !sb.flush;
  assign inc_any = sb.issue_fire && sb.issue_wen && sb.issue_wa != '0;
  // a wb counts toward tot unless it underflows its own register
  assign dec_eff = sb.wb_valid && sb.wb_wa != '0
                   && (cnt[sb.wb_wa] != '0 || (inc_any && sb.issue_wa == sb.wb_wa));
  assign sb.sb_empty = tot == '0;
  assign sb.sb_err = err_q;
  always_ff @(posedge clk)
    if (reset || sb.flush) tot <= '0;
    else if (inc_any && !dec_eff) tot <= tot + TOT_W'(1);
    else if (dec_eff && !inc_any) tot <= tot - TOT_W'(1);
  always_ff @(posedge clk)
    if (reset) err_q <= 1'b0;
    else if (|uf) err_q <= 1'b1;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed checks of the scoreboard, default and WAW_STALL=0 builds.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;
  logic clk, rst, iv, wen, wbv, fl;
  creg_addr_t wa, r1, r2, wbwa;
  int passed = 0, total = 0, fails = 0;
  reg_scoreboard_if ia ();
  reg_scoreboard_if ib ();
  assign ia.issue_valid = iv;
  assign ia.issue_wen = wen;
  assign ia.issue_wa = wa;
  assign ia.ra1 = r1;
  assign ia.ra2 = r2;
  assign ia.wb_valid = wbv;
  assign ia.wb_wa = wbwa;
  assign ia.flush = fl;
  assign ib.issue_valid = iv;
  assign ib.issue_wen = wen;
  assign ib.issue_wa = wa;
  assign ib.ra1 = r1;
  assign ib.ra2 = r2;
  assign ib.wb_valid = wbv;
  assign ib.wb_wa = wbwa;
  assign ib.flush = fl;
  reg_scoreboard u_a (.clk(clk), .reset(rst), .sb(ia.slave));
  reg_scoreboard #(.WAW_STALL(1'b0)) u_b (.clk(clk), .reset(rst), .sb(ib.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic idle();
    iv = 0; wen = 0; wa = 0; r1 = 0; r2 = 0; wbv = 0; wbwa = 0; fl = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input creg_addr_t a);
    iv = 1; wen = 1; wa = a;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  initial begin
    do_reset();
    iv = 1; #1;
    chk("rst_busy1", ia.busy1, 0);
    chk("rst_busy2", ia.busy2, 0);
    chk("rst_stall", ia.issue_stall, 0);
    chk("rst_fire", ia.issue_fire, 1);
    chk("rst_empty", ia.sb_empty, 1);
    chk("rst_err", ia.sb_err, 0);
    idle(); issue(5); #1;
    chk("i5_fire", ia.issue_fire, 1);
    tick();
    idle(); iv = 1; r1 = 5; #1;
    chk("raw_busy1", ia.busy1, 1);
    chk("raw_stall", ia.issue_stall, 1);
    chk("raw_fire", ia.issue_fire, 0);
    chk("raw_empty", ia.sb_empty, 0);
    wbv = 1; wbwa = 5; #1;
    chk("byp_busy1", ia.busy1, 0);
    chk("byp_fire", ia.issue_fire, 1);
    tick();
    idle(); #1;
    chk("wb5_empty", ia.sb_empty, 1);
    chk("wb5_err", ia.sb_err, 0);
    issue(0); r1 = 0; #1;
    chk("x0_busy1", ia.busy1, 0);
    chk("x0_fire", ia.issue_fire, 1);
    tick();
    idle(); r1 = 0; #1;
    chk("x0_empty", ia.sb_empty, 1);
    wbv = 1; wbwa = 0;
    tick();
    idle(); #1;
    chk("x0_wb_err", ia.sb_err, 0);
    chk("x0_wb_empty", ia.sb_empty, 1);
    issue(7); #1;
    chk("b7a_fire", ib.issue_fire, 1);
    tick();
    issue(7); #1;
    chk("a7_waw_stall", ia.issue_stall, 1);
    chk("b7b_fire", ib.issue_fire, 1);
    tick();
    issue(7); #1;
    chk("b7c_fire", ib.issue_fire, 1);
    tick();
    issue(7); #1;
    chk("b7_sat_stall", ib.issue_stall, 1);
    wbv = 1; wbwa = 7; #1;
    chk("b7_sat_wb_stall", ib.issue_stall, 1);
    chk("b7_sat_wb_fire", ib.issue_fire, 0);
    chk("a7_byp_fire", ia.issue_fire, 1);
    tick();
    idle(); issue(7); #1;
    chk("b7_after_fire", ib.issue_fire, 1);
    chk("a7_still_stall", ia.issue_stall, 1);
    tick();
    idle(); r1 = 7; #1;
    chk("b7_busy", ib.busy1, 1);
    chk("b7_err", ib.sb_err, 0);
    do_reset();
    #1;
    chk("rst2_empty", ib.sb_empty, 1);
    chk("rst2_err", ib.sb_err, 0);
    issue(3);
    tick();
    issue(3); r1 = 3; wbv = 1; wbwa = 3; #1;
    chk("p3_fire", ia.issue_fire, 1);
    chk("p3_byp_busy", ia.busy1, 0);
    tick();
    idle(); r1 = 3; #1;
    chk("p3_busy_next", ia.busy1, 1);
    chk("p3_empty", ia.sb_empty, 0);
    wbv = 1; wbwa = 3;
    tick();
    idle(); r2 = 3; #1;
    chk("p3_busy_done", ia.busy2, 0);
    chk("p3_empty_done", ia.sb_empty, 1);
    chk("p3_err", ia.sb_err, 0);
    wbv = 1; wbwa = 9;
    tick();
    idle(); #1;
    chk("uf_err", ia.sb_err, 1);
    chk("uf_empty", ia.sb_empty, 1);
    fl = 1;
    tick();
    idle(); #1;
    chk("uf_err_flush", ia.sb_err, 1);
    issue(4);
    tick();
    issue(6); r1 = 4; #1;
    chk("f4_busy1", ia.busy1, 1);
    idle(); issue(6);
    tick();
    issue(8); fl = 1; #1;
    chk("fl_stall", ia.issue_stall, 0);
    chk("fl_fire", ia.issue_fire, 0);
    chk("fl_empty_pre", ia.sb_empty, 0);
    tick();
    idle(); r1 = 4; r2 = 6; #1;
    chk("fl_busy1", ia.busy1, 0);
    chk("fl_busy2", ia.busy2, 0);
    chk("fl_empty", ia.sb_empty, 1);
    r1 = 8; #1;
    chk("fl_busy8", ia.busy1, 0);
    chk("fl_err_kept", ia.sb_err, 1);
    do_reset();
    #1;
    chk("rst3_err", ia.sb_err, 0);
    chk("rst3_empty", ia.sb_empty, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-hazard scoreboard for the in-order pipeline.
- Decode records each issued instruction's destination register. Writeback retires it.
- Decode queries source registers and receives a stall.
- Together with the forwarding unit, it closes the hazard protocol: it produces and tracks pending-write state instead of consuming per-stage write addresses. This is what multi-cycle units (mul/div, memory) need.

Parameters:
- NREG, 32, number of architectural integer registers.
- CNT_W, 2, width of each per-register in-flight counter (max 2^CNT_W-1 pending writes).
- WB_BYPASS, 1, if 1 a same-cycle writeback that retires the last pending write clears busy for queries in that cycle.
- WAW_STALL, 1, if 1 issue also stalls when its destination already has a pending write.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- issue_valid, input, 1, decode holds a valid instruction.
- issue_wen, input, 1, instruction writes a register.
- issue_wa, input, 5 (creg_addr_t), destination register.
- ra1, input, 5 (creg_addr_t), source register 1.
- ra2, input, 5 (creg_addr_t), source register 2.
- wb_valid, input, 1, writeback retires a register write this cycle.
- wb_wa, input, 5 (creg_addr_t), register being written back.
- flush, input, 1, squash all tracked writes (asserted only after older writes have drained).
- busy1, output, 1, ra1 has a pending write.
- busy2, output, 1, ra2 has a pending write.
- issue_stall, output, 1, decode must hold; issue not accepted.
- issue_fire, output, 1, issue accepted this cycle.
- sb_empty, output, 1, no pending writes anywhere.
- sb_err, output, 1, sticky protocol error.

Behaviour:
- State: cnt[NREG] of CNT_W bits, total pending counter tot, and sb_err. All registered.
- Reset (synchronous): cnt = 0, tot = 0, sb_err = 0.
- Outputs after reset: busy1 = busy2 = 0, issue_stall = 0, issue_fire = issue_valid, sb_empty = 1.
- Register x0: never tracked. Issue or wb to x0 does not change state. busy for x0 is always 0.
- wb_clear(r) = wb_valid && wb_wa == r && r != 0 && cnt[r] == 1 && WB_BYPASS.
- busyN = (raN != 0) && cnt[raN] != 0 && !wb_clear(raN). This is combinational from state and the current-cycle wb only.
- waw = WAW_STALL && issue_wen && issue_wa != 0 && cnt[issue_wa] != 0 && !wb_clear(issue_wa).
- sat = issue_wen && issue_wa != 0 && cnt[issue_wa] == max.
  - A same-cycle wb to that register does not relieve sat.
- issue_stall = issue_valid && (busy1 || busy2 || waw || sat).
- issue_fire = issue_valid && !issue_stall && !flush.
- Next state per register r (r != 0):
  - inc = issue_fire && issue_wen && issue_wa == r.
  - dec = wb_valid && wb_wa == r.
  - inc && dec: cnt unchanged.
  - inc only: cnt + 1.
  - dec only with cnt > 0: cnt - 1.
  - dec with cnt == 0: cnt unchanged and sb_err set (underflow).
- tot tracks the sum of counters with the same rules. tot width is clog2(NREG*(2^CNT_W-1)+1). sb_empty = (tot == 0).
- flush: next cycle cnt = 0 and tot = 0, overriding any same-cycle issue and wb. sb_err is not cleared.
- sb_err is cleared only by reset.
- Latency:
  - An accepted issue is visible to queries from the next cycle.
  - With WB_BYPASS, a retiring wb is visible in the same cycle. Otherwise it is visible the next cycle.
- Reset mid-operation: all pending state is discarded with no error.

Decomposition:
- The shared pipes package gets:
  - a scoreboard counter typedef sized by CNT_W;
  - the constant NREG;
  - the existing creg_addr_t.
- One natural sub-module: sb_entry. It holds a single register's counter with inc/dec/flush/err logic and is instanced NREG-1 times.
- The top level holds the address decode, query muxes, tot and the output logic.

Test Plan:
- Reset, then issue wa=5 (fire=1). Next cycle ra1=5 gives busy1=1 and issue_stall=1. wb wa=5 with ra1=5 in the same cycle gives busy1=0, issue_fire=1 (bypass). The following cycle sb_empty=1.
- Issue wa=0 and query ra1=0 -> busy1=0, no state change, sb_empty stays 1.
- WAW_STALL=0: issue wa=7 three times -> cnt=3. A fourth issue to wa=7 gives issue_stall=1 (sat), even with wb wa=7 in that cycle. After that wb, cnt=2 and the next issue fires.
- Issue wa=3 and wb wa=3 together while cnt[3]=1 -> cnt[3] stays 1, busy for ra=3 stays 1 next cycle.
- wb wa=9 with cnt[9]=0 -> sb_err=1 and stays 1 through flush. Cleared only by reset.
- Issue wa=4 and wa=6 in two consecutive cycles, then flush with issue wa=8 in the same cycle -> issue_fire=0, next cycle all busy=0, sb_empty=1.
